// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: registered one-hot grants, a per-tenure hold limit
// that forces a timeout, and a per-requester mask. The mask keeps a
// timed-out controller off the bus until it drops and re-raises its request.
module bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 64
) (
  input  logic                     BUS_CLK,
  input  logic                     RST,
  input  logic [N_REQ-1:0]         BR,
  output logic [N_REQ-1:0]         BG,
  output logic [$clog2(N_REQ)-1:0] GRANT_ID,
  output logic                     BUS_BUSY,
  output logic                     TIMEOUT
);
  localparam int IW = $clog2(N_REQ);
  localparam logic [7:0]       HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [N_REQ-1:0] ONE       = N_REQ'(1);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t           state_q;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    owner_q;
  logic [7:0]       hold_q;
  logic [N_REQ-1:0] mask_q;

  logic [N_REQ-1:0] elig;
  logic             any_elig;
  logic [IW-1:0]    win_id;
  logic [IW-1:0]    idx;
  logic             found;

  // Pick the first eligible requester, starting the search at ptr_q.
  always_comb begin
    elig     = BR & ~mask_q;
    any_elig = |elig;
    win_id   = '0;
    idx      = '0;
    found    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IW'((int'(ptr_q) + k) % N_REQ);
      if (!found && elig[idx]) begin
        found  = 1'b1;
        win_id = idx;
      end
    end
  end

  // Arbitration FSM. All outputs are flops, so BR has no combinational path
  // to any output.
  always_ff @(posedge BUS_CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      BG       <= '0;
      GRANT_ID <= '0;
      BUS_BUSY <= 1'b0;
      TIMEOUT  <= 1'b0;
      ptr_q    <= '0;
      owner_q  <= '0;
      hold_q   <= '0;
      mask_q   <= '0;
    end else begin
      TIMEOUT <= 1'b0;
      // A mask bit clears as soon as its request is seen low.
      mask_q  <= mask_q & BR;
      case (state_q)
        IDLE, TURN: begin
          if (any_elig) begin
            state_q  <= GRANT;
            BG       <= ONE << win_id;
            GRANT_ID <= win_id;
            BUS_BUSY <= 1'b1;
            owner_q  <= win_id;
            ptr_q    <= win_id + IW'(1);
            hold_q   <= '0;
          end else begin
            state_q  <= IDLE;
            BG       <= '0;
            GRANT_ID <= '0;
            BUS_BUSY <= 1'b0;
          end
        end
        GRANT: begin
          if (!BR[owner_q] || hold_q == HOLD_LAST) begin
            // A release takes priority over the hold limit, so an owner that
            // drops on the limit cycle is neither flagged nor masked.
            state_q  <= TURN;
            BG       <= '0;
            GRANT_ID <= '0;
            BUS_BUSY <= 1'b0;
            if (BR[owner_q]) begin
              TIMEOUT <= 1'b1;
              mask_q  <= (mask_q & BR) | (ONE << owner_q);
            end
          end else begin
            hold_q <= hold_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, single tenure, round-robin order,
// reset in mid-tenure, hold-limit timeout, limit collision and non-owner noise.
module tb_bus_arbiter;
  logic       BUS_CLK = 1'b0;
  logic       RST;
  logic [3:0] BR;
  logic [3:0] BG;
  logic [1:0] GRANT_ID;
  logic       BUS_BUSY;
  logic       TIMEOUT;

  int n_cmp = 0;
  int n_err = 0;
  int cnt;
  int to_seen;
  int e;

  bus_arbiter #(.N_REQ(4), .MAX_HOLD(64)) dut (
    .BUS_CLK (BUS_CLK),
    .RST     (RST),
    .BR      (BR),
    .BG      (BG),
    .GRANT_ID(GRANT_ID),
    .BUS_BUSY(BUS_BUSY),
    .TIMEOUT (TIMEOUT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the #1 keeps sampling and driving off the edge.
  task automatic step();
    @(posedge BUS_CLK);
    #1;
  endtask

  task automatic rst_pulse();
    RST = 1'b0;
    #2;
    RST = 1'b1;
  endtask

  initial begin
    RST = 1'b0;
    BR  = 4'b0000;
    #3;
    chk("rst_bg",   32'(BG), 'h0);
    chk("rst_id",   32'(GRANT_ID), 'h0);
    chk("rst_busy", 32'(BUS_BUSY), 'h0);
    chk("rst_to",   32'(TIMEOUT), 'h0);
    step();
    RST = 1'b1;
    step();
    step();
    chk("idle_bg", 32'(BG), 'h0);

    // Single request on index 2, held for six sampling edges.
    BR = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("single_bg", 32'(BG), 'h4);
      chk("single_id", 32'(GRANT_ID), 'h2);
      chk("single_to", 32'(TIMEOUT), 'h0);
    end
    BR = 4'b0000;
    step();
    chk("single_rel_bg",   32'(BG), 'h0);
    chk("single_rel_busy", 32'(BUS_BUSY), 'h0);
    chk("single_rel_id",   32'(GRANT_ID), 'h0);
    step();

    // Round-robin with every controller requesting.
    rst_pulse();
    BR = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      e = i % 4;
      for (int c = 0; c < 3; c++) begin
        chk("rr_bg",   32'(BG), 32'(1 << e));
        chk("rr_id",   32'(GRANT_ID), 32'(e));
        chk("rr_busy", 32'(BUS_BUSY), 'h1);
        if (c < 2) step();
      end
      BR[e] = 1'b0;
      step();
      chk("rr_turn_bg", 32'(BG), 'h0);
      BR = 4'b1111;
      step();
    end
    BR = 4'b0000;
    step();
    step();

    // Non-owner noise must not disturb an existing tenure.
    rst_pulse();
    BR = 4'b0001;
    step();
    chk("noise_grant", 32'(BG), 'h1);
    for (int c = 0; c < 8; c++) begin
      BR = (c % 2 == 0) ? 4'b1011 : 4'b0101;
      step();
      chk("noise_bg", 32'(BG), 'h1);
    end
    BR = 4'b0000;
    step();
    chk("noise_rel", 32'(BG), 'h0);
    step();

    // Reset in mid-tenure drops the grant without a clock edge.
    rst_pulse();
    BR = 4'b0010;
    step();
    chk("mid_grant", 32'(BG), 'h2);
    #2;
    RST = 1'b0;
    #1;
    chk("mid_rst_bg",   32'(BG), 'h0);
    chk("mid_rst_busy", 32'(BUS_BUSY), 'h0);
    chk("mid_rst_id",   32'(GRANT_ID), 'h0);
    chk("mid_rst_to",   32'(TIMEOUT), 'h0);
    #2;
    BR  = 4'b1111;
    RST = 1'b1;
    step();
    chk("post_rst_bg", 32'(BG), 'h1);
    chk("post_rst_id", 32'(GRANT_ID), 'h0);
    BR = 4'b0000;
    step();
    step();

    // Hold limit: BR[1] stays high, BR[3] waits. Pointer is 1 here.
    BR = 4'b1010;
    step();
    cnt = 0;
    to_seen = 0;
    for (int c = 0; c < 80 && BG == 4'b0010; c++) begin
      cnt++;
      if (TIMEOUT) to_seen++;
      step();
    end
    chk("to_hold_cycles", 32'(cnt), 'd64);
    chk("to_early_pulse", 32'(to_seen), 'h0);
    chk("to_bg",    32'(BG), 'h0);
    chk("to_pulse", 32'(TIMEOUT), 'h1);
    step();
    chk("to_next_bg", 32'(BG), 'h8);
    chk("to_next_id", 32'(GRANT_ID), 'h3);
    chk("to_pulse_end", 32'(TIMEOUT), 'h0);
    BR = 4'b0010;
    step();
    chk("to_turn", 32'(BG), 'h0);
    step();
    chk("masked_1", 32'(BG), 'h0);
    step();
    chk("masked_2", 32'(BG), 'h0);
    BR = 4'b0000;
    step();
    BR = 4'b0010;
    step();
    chk("unmasked_regrant", 32'(BG), 'h2);
    BR = 4'b0000;
    step();
    step();

    // Owner drops on exactly the limit cycle: normal release, no mask.
    BR = 4'b0001;
    step();
    chk("col_grant", 32'(BG), 'h1);
    to_seen = 0;
    for (int c = 0; c < 63; c++) begin
      step();
      if (TIMEOUT) to_seen++;
    end
    chk("col_held", 32'(BG), 'h1);
    chk("col_no_early_to", 32'(to_seen), 'h0);
    BR = 4'b0000;
    step();
    chk("col_bg", 32'(BG), 'h0);
    chk("col_to", 32'(TIMEOUT), 'h0);
    BR = 4'b0001;
    step();
    chk("col_regrant", 32'(BG), 'h1);
    BR = 4'b0000;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of bus controllers sharing the system bus; fixed at 4 in this revision.
REQ-002 Parameter MAX_HOLD, default 64, maximum consecutive grant cycles per tenure; legal range 2..255.
REQ-003 BUS_CLK  input  1  bus clock; all state updates on its rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 BR  input  4  bus requests; bit i from controller i, held high for the whole transaction.
REQ-006 BG  output  4  bus grants; one-hot or all-zero, registered.
REQ-007 GRANT_ID  output  2  index of the current owner; 0 when no owner.
REQ-008 BUS_BUSY  output  1  high while any BG bit is high.
REQ-009 TIMEOUT  output  1  one-cycle pulse when a tenure is forcibly ended.

Function
REQ-010 State machine has three states: IDLE, GRANT and TURN.
REQ-011 BG, GRANT_ID, BUS_BUSY and TIMEOUT shall be flop outputs with no combinational path from BR.
REQ-012 In IDLE or TURN, if any eligible BR bit is sampled high, the arbiter shall assert BG for the winner at that edge and enter GRANT; otherwise it shall go to or stay in IDLE with BG=0.
REQ-013 Eligible means BR[i]=1 and MASK[i]=0.
REQ-014 The winner is the first eligible index searching PTR, PTR+1, ... modulo 4.
REQ-015 PTR is a 2-bit round-robin pointer; on each grant to owner k it shall load (k+1) mod 4, wrapping 3 to 0.
REQ-016 Grant latency: BR rising before edge n with the bus in IDLE gives BG high after edge n.
REQ-017 In GRANT, BG[owner] shall stay high while BR[owner] is sampled high and the hold limit has not been reached.
REQ-018 In GRANT, BR changes on non-owner bits shall not affect BG.
REQ-019 When BR[owner] is sampled low in GRANT, BG shall clear at that edge and the state shall become TURN, giving exactly one cycle with all BG=0 before any new grant.
REQ-020 A hold counter, 8 bits, shall clear on grant and increment each GRANT cycle.
REQ-021 When the hold counter equals MAX_HOLD-1 and BR[owner] is still high, the arbiter shall end the tenure: clear BG, enter TURN, pulse TIMEOUT for one cycle and set MASK[owner].
REQ-022 A BG tenure shall last at most MAX_HOLD cycles.
REQ-023 MASK[i] shall clear on the first edge at which BR[i] is sampled low; a masked requester shall not be granted until it has dropped and re-raised BR.
REQ-024 If the owner drops BR in the same cycle the limit is reached, this is a normal release: TIMEOUT=0 and MASK is unchanged.
REQ-025 GRANT_ID shall update on the same edge as BG and return to 0 when BG clears.
REQ-026 BUS_BUSY shall equal the OR of BG.
REQ-027 BR bits that are all low in IDLE shall cause no state, pointer or mask change.

Reset
REQ-028 While RST=0, the following shall be forced immediately, independent of BUS_CLK:
- state IDLE
- BG=0000, GRANT_ID=0, BUS_BUSY=0, TIMEOUT=0
- PTR=0, hold counter=0, MASK=0000
REQ-029 On release of RST, the first arbitration shall occur at the next rising BUS_CLK edge.
REQ-030 Reset asserted mid-tenure shall drop BG without a TURN cycle or TIMEOUT pulse.

Verification
REQ-031 Single request: raise BR=0100 for 6 cycles then drop -> BG=0100 one edge after the request, held 6 cycles; cleared on the edge sampling BR[2]=0; GRANT_ID=2 during the tenure; TIMEOUT never pulses.
REQ-032 Round-robin: BR=1111 continuously, each owner drops its bit for one cycle after 3 grant cycles -> grant order 0,1,2,3,0; one all-zero TURN cycle between tenures.
REQ-033 Timeout with MAX_HOLD=64: BR[1] held 100 cycles, BR[3] high -> BG[1] high exactly 64 cycles, TIMEOUT=1 for one cycle, then BG=1000 after one TURN cycle; BR[1] not regranted until it drops and re-rises.
REQ-034 Limit collision: owner drops BR exactly in cycle 64 -> normal release, TIMEOUT=0, MASK=0000.
REQ-035 Reset mid-grant: RST=0 while BG=0010 -> BG=0000 and BUS_BUSY=0 without a clock edge; after release with BR=1111, first grant goes to index 0.
REQ-036 Non-owner noise: while BG=0001, toggle BR[3:1] every cycle -> BG stays 0001 until BR[0] drops.
